// File: rtl/fp_rnd_seq_pkg.sv
// Shared types for the FP rounding/packing stage: rounding modes, fflags
// bit positions, canonical NaN encodings and the sequencer state encoding.
package fp_rnd_seq_pkg;

  localparam int FLEN_DEF = 64;
  localparam int EXPW_DEF = 14;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Bit positions inside fflags = {NV,DZ,OF,UF,NX}
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  // Single NaN is NaN-boxed into the upper 32 bits
  localparam logic [63:0] NAN_S = 64'hFFFF_FFFF_7FC0_0000;
  localparam logic [63:0] NAN_D = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_PACK  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/fp_rnd_seq_if.sv
// Producer/consumer bundle of the rounding stage. The slave modport is the
// rounding stage itself; the master modport is the surrounding FPU.
interface fp_rnd_seq_if #(
  parameter int FLEN = 64,
  parameter int EXPW = 14
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   sig;
  logic signed [EXPW-1:0] expo;
  logic [53:0]            mant;
  logic [1:0]             rema;
  logic [1:0]             fmt;
  logic [2:0]             rm;
  logic [2:0]             grs;
  logic                   snan;
  logic                   qnan;
  logic                   dbz;
  logic                   infs;
  logic                   zero;
  logic                   diff;
  logic                   out_valid;
  logic                   out_ready;
  logic [FLEN-1:0]        result;
  logic [4:0]             fflags;

  modport master (
    output in_valid, sig, expo, mant, rema, fmt, rm, grs,
           snan, qnan, dbz, infs, zero, diff, out_ready,
    input  in_ready, out_valid, result, fflags
  );

  modport slave (
    input  in_valid, sig, expo, mant, rema, fmt, rm, grs,
           snan, qnan, dbz, infs, zero, diff, out_ready,
    output in_ready, out_valid, result, fflags
  );
endinterface

// File: rtl/fp_rnd_inc.sv
// Combinational round-up decision and mantissa increment. The mantissa is
// LSB-aligned; single precision only uses the low 24 bits.
module fp_rnd_inc
  import fp_rnd_seq_pkg::*;
(
  input  logic [52:0] i_mant,
  input  logic        i_dbl,
  input  logic [2:0]  i_rm,
  input  logic        i_sig,
  input  logic [2:0]  i_grs,
  input  logic [1:0]  i_rema,
  output logic [53:0] o_sum,
  output logic        o_inexact
);

  // Reserved encodings 5..7 fall through to round-to-nearest-even.
  function automatic logic f_round_up(input logic [2:0] rm, input logic sig,
                                      input logic g, input logic r,
                                      input logic s, input logic lsb);
    logic inx;
    inx = g | r | s;
    case (rm)
      RM_RTZ:  f_round_up = 1'b0;
      RM_RDN:  f_round_up = sig & inx;
      RM_RUP:  f_round_up = ~sig & inx;
      RM_RMM:  f_round_up = g;
      default: f_round_up = g & (r | s | lsb);
    endcase
  endfunction

  logic [52:0] w_m;
  logic        w_s;
  logic        w_inc;

  // Remainder bits from div/sqrt only ever make the result more inexact.
  always_comb begin
    w_m       = i_dbl ? i_mant : {29'd0, i_mant[23:0]};
    w_s       = i_grs[0] | i_rema[1] | i_rema[0];
    o_inexact = i_grs[2] | i_grs[1] | w_s;
    w_inc     = f_round_up(i_rm, i_sig, i_grs[2], i_grs[1], w_s, w_m[0]);
    o_sum     = {1'b0, w_m} + {53'd0, w_inc};
  end

endmodule

// File: rtl/fp_rnd_seq.sv
// Sequential IEEE 754 round-and-pack stage (IDLE -> ROUND -> PACK -> OUT).
// One record in flight; FP32 results are NaN-boxed into FLEN bits.
// Build option FP_RND_FTZ_EN: flush subnormal results to signed zero.
module fp_rnd_seq
  import fp_rnd_seq_pkg::*;
#(
  parameter int FLEN = FLEN_DEF,
  parameter int EXPW = EXPW_DEF
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clear,
  fp_rnd_seq_if.slave bus
);

  localparam logic signed [EXPW-1:0] E_ZERO = '0;
  localparam logic signed [EXPW-1:0] E_ONE  = 1;
  localparam logic signed [EXPW-1:0] EMAX_S = 255;
  localparam logic signed [EXPW-1:0] EMAX_D = 2047;

  function automatic logic [63:0] f_pack(input logic dbl, input logic s,
                                         input logic [10:0] e,
                                         input logic [51:0] frac);
    f_pack = dbl ? {s, e, frac} : {32'hFFFF_FFFF, s, e[7:0], frac[22:0]};
  endfunction

  // Saturate to infinity only when the rounding direction points away from zero.
  function automatic logic f_ovf_to_inf(input logic [2:0] rm, input logic sig);
    case (rm)
      RM_RTZ:  f_ovf_to_inf = 1'b0;
      RM_RDN:  f_ovf_to_inf = sig;
      RM_RUP:  f_ovf_to_inf = ~sig;
      default: f_ovf_to_inf = 1'b1;
    endcase
  endfunction

  state_e                 r_state, w_next;
  logic                   r_sig, r_dbl, r_snan, r_qnan, r_dbz, r_infs, r_zero, r_diff;
  logic signed [EXPW-1:0] r_expo;
  logic [52:0]            r_mant;
  logic [1:0]             r_rema;
  logic [2:0]             r_rm, r_grs;
  logic                   r_inexact, r_uf_cand;
  logic [51:0]            r_frac;
  logic                   r_out_valid;
  logic [FLEN-1:0]        r_result;
  logic [4:0]             r_fflags;

  logic [53:0]            w_sum;
  logic                   w_inexact, w_carry, w_hidden;
  logic [51:0]            w_frac_rnd;
  logic signed [EXPW-1:0] w_expo_rnd, w_emax;
  logic [63:0]            w_pack;
  logic [4:0]             w_flags;
  logic                   w_unused;

  assign w_unused      = bus.mant[53];
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.fflags    = r_fflags;

  fp_rnd_inc u_inc (
    .i_mant   (r_mant),
    .i_dbl    (r_dbl),
    .i_rm     (r_rm),
    .i_sig    (r_sig),
    .i_grs    (r_grs),
    .i_rema   (r_rema),
    .o_sum    (w_sum),
    .o_inexact(w_inexact)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; clear flushes from any state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_ROUND;
      S_ROUND: w_next = S_PACK;
      S_PACK:  w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  // Mantissa carry renormalises; a subnormal rounding into the hidden bit becomes normal
  always_comb begin
    w_carry    = r_dbl ? w_sum[53] : w_sum[24];
    w_hidden   = r_dbl ? w_sum[52] : w_sum[23];
    if (r_dbl) w_frac_rnd = w_carry ? w_sum[52:1] : w_sum[51:0];
    else       w_frac_rnd = w_carry ? {29'd0, w_sum[23:1]} : {29'd0, w_sum[22:0]};
    w_expo_rnd = r_expo + (w_carry ? E_ONE : E_ZERO);
    if ((r_expo == E_ZERO) && w_hidden) w_expo_rnd = E_ONE;
  end

  // Record capture in IDLE and rounded mantissa/exponent in ROUND
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.in_valid && !clear) begin
      r_sig     <= bus.sig;
      r_expo    <= bus.expo;
      r_mant    <= bus.mant[52:0];
      r_rema    <= bus.rema;
      r_dbl     <= (bus.fmt == 2'd1);
      r_rm      <= bus.rm;
      r_grs     <= bus.grs;
      r_snan    <= bus.snan;
      r_qnan    <= bus.qnan;
      r_dbz     <= bus.dbz;
      r_infs    <= bus.infs;
      r_zero    <= bus.zero;
      r_diff    <= bus.diff;
      r_uf_cand <= (bus.expo == E_ZERO);
    end
    if (r_state == S_ROUND) begin
      r_frac    <= w_frac_rnd;
      r_expo    <= w_expo_rnd;
      r_inexact <= w_inexact;
    end
  end

  // Final encoding: specials first, then overflow, then finite pack
  always_comb begin
    w_pack  = '0;
    w_flags = '0;
    w_emax  = r_dbl ? EMAX_D : EMAX_S;
    if (r_snan) begin
      w_pack         = r_dbl ? NAN_D : NAN_S;
      w_flags[FF_NV] = 1'b1;
    end else if (r_qnan) begin
      w_pack = r_dbl ? NAN_D : NAN_S;
    end else if (r_dbz) begin
      w_pack         = f_pack(r_dbl, r_sig, 11'h7FF, 52'd0);
      w_flags[FF_DZ] = 1'b1;
    end else if (r_infs) begin
      w_pack = f_pack(r_dbl, r_sig, 11'h7FF, 52'd0);
    end else if (r_zero) begin
      // An exact cancellation (x - x) is -0 only when rounding down
      w_pack = f_pack(r_dbl, r_diff ? (r_rm == RM_RDN) : r_sig, 11'd0, 52'd0);
    end else if (r_expo >= w_emax) begin
      w_flags[FF_OF] = 1'b1;
      w_flags[FF_NX] = 1'b1;
      if (f_ovf_to_inf(r_rm, r_sig)) w_pack = f_pack(r_dbl, r_sig, 11'h7FF, 52'd0);
      else                           w_pack = f_pack(r_dbl, r_sig, 11'h7FE, '1);
    end else begin
      w_pack         = f_pack(r_dbl, r_sig, r_expo[10:0], r_frac);
      w_flags[FF_NX] = r_inexact;
      w_flags[FF_UF] = r_uf_cand & r_inexact;
`ifdef FP_RND_FTZ_EN
      if ((r_expo == E_ZERO) && (r_dbl ? (|r_frac) : (|r_frac[22:0]))) begin
        w_pack         = f_pack(r_dbl, r_sig, 11'd0, 52'd0);
        w_flags[FF_UF] = 1'b1;
        w_flags[FF_NX] = 1'b1;
      end
`endif
    end
  end

  // Output registers: loaded leaving PACK, held through OUT until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_fflags    <= '0;
    end else begin
      r_out_valid <= (w_next == S_OUT);
      if ((r_state == S_PACK) && !clear) begin
        r_result <= w_pack[FLEN-1:0];
        r_fflags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_rnd_seq.sv
// Randomised bench for fp_rnd_seq with a value-level rounding model,
// literal anchor vectors, handshake-hold and clear scenarios.
module tb_fp_rnd_seq;

  typedef struct {
    bit              sig;
    int              expo;
    longint unsigned mant;
    bit [1:0]        rema;
    bit [1:0]        fmt;
    bit [2:0]        rm;
    bit [2:0]        grs;
    bit              snan, qnan, dbz, infs, zero, diff;
  } rec_t;

  logic clk;
  logic rst_n;
  logic clear;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rdy_mode = 1;

  logic [68:0] exp_q[$];
  int          cyc_q[$];
  bit          first_pend = 1'b1;

  rec_t        dv[13];
  logic [63:0] dres[13];
  logic [4:0]  dfl[13];

  fp_rnd_seq_if #(.FLEN(64), .EXPW(14)) bus ();

  fp_rnd_seq #(.FLEN(64), .EXPW(14)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] pk(input bit dbl, input bit s, input int e,
                                     input longint unsigned frac);
    logic [10:0] e11;
    e11 = e[10:0];
    if (dbl) pk = {s, e11, frac[51:0]};
    else     pk = {32'hFFFF_FFFF, s, e11[7:0], frac[22:0]};
  endfunction

  // Rounding described by the value of the discarded fraction in eighths of an ulp.
  function automatic void model(input rec_t r, output logic [63:0] res, output logic [4:0] fl);
    bit dbl, inexact, up, sgn;
    int p, emax, f, mode, e;
    longint unsigned one, m, rv, frac, fmask;
    one   = 1;
    dbl   = (r.fmt == 2'd1);
    p     = dbl ? 53 : 24;
    emax  = dbl ? 2047 : 255;
    m     = r.mant & ((one << p) - 1);
    f     = 4 * int'(r.grs[2]) + 2 * int'(r.grs[1]) + int'(r.grs[0] | (r.rema != 2'd0));
    inexact = (f != 0);
    mode  = (r.rm > 3'd4) ? 0 : int'(r.rm);
    case (mode)
      0:       up = (f > 4) || (f == 4 && m[0]);
      1:       up = 1'b0;
      2:       up = r.sig && inexact;
      3:       up = !r.sig && inexact;
      default: up = (f >= 4);
    endcase
    rv = m + (up ? one : 64'd0);
    e  = r.expo;
    if (rv == (one << p)) begin
      rv = rv >> 1;
      e  = e + 1;
    end
    if (e == 0 && rv >= (one << (p - 1))) e = 1;
    fmask = (one << (p - 1)) - 1;
    frac  = rv & fmask;
    fl    = 5'b00000;
    if (r.snan) begin
      res = dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
      fl  = 5'b10000;
    end else if (r.qnan) begin
      res = dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
    end else if (r.dbz) begin
      res = pk(dbl, r.sig, 2047, 0);
      fl  = 5'b01000;
    end else if (r.infs) begin
      res = pk(dbl, r.sig, 2047, 0);
    end else if (r.zero) begin
      sgn = r.diff ? (r.rm == 3'd2) : r.sig;
      res = pk(dbl, sgn, 0, 0);
    end else if (e >= emax) begin
      fl = 5'b00101;
      if (mode == 0 || mode == 4 || (mode == 3 && !r.sig) || (mode == 2 && r.sig))
        res = pk(dbl, r.sig, 2047, 0);
      else
        res = pk(dbl, r.sig, emax - 1, fmask);
    end else begin
      res = pk(dbl, r.sig, e, frac);
      fl  = {3'b000, (r.expo == 0) && inexact, inexact};
`ifdef FP_RND_FTZ_EN
      if (e == 0 && frac != 0) begin
        res = pk(dbl, r.sig, 0, 0);
        fl  = 5'b00011;
      end
`endif
    end
  endfunction

  function automatic rec_t mk(input bit [1:0] fmt, input int expo, input longint unsigned mant,
                              input bit [2:0] grs, input bit [2:0] rm, input bit sig);
    rec_t r;
    r.sig = sig; r.expo = expo; r.mant = mant; r.rema = 2'b00; r.fmt = fmt;
    r.rm = rm; r.grs = grs;
    r.snan = 0; r.qnan = 0; r.dbz = 0; r.infs = 0; r.zero = 0; r.diff = 0;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    int p, emax, sel;
    longint unsigned one, hid;
    one    = 1;
    r.fmt  = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd0;
    p      = (r.fmt == 2'd1) ? 53 : 24;
    emax   = (r.fmt == 2'd1) ? 2047 : 255;
    sel    = int'($urandom_range(0, 5));
    if (sel == 0)      r.expo = 0;
    else if (sel == 1) r.expo = int'($urandom_range(emax - 2, emax + 1));
    else               r.expo = int'($urandom_range(1, emax - 1));
    r.mant = {$urandom, $urandom};
    hid    = one << (p - 1);
    if ($urandom_range(0, 3) == 0) r.mant = r.mant | (hid - 1);
    if (r.expo == 0) r.mant = r.mant & ~hid;
    else             r.mant = r.mant | hid;
    r.sig  = 1'($urandom_range(0, 1));
    r.rema = 2'($urandom_range(0, 3));
    r.rm   = 3'($urandom_range(0, 7));
    r.grs  = 3'($urandom_range(0, 7));
    r.snan = ($urandom_range(0, 15) == 0);
    r.qnan = ($urandom_range(0, 15) == 0);
    r.dbz  = ($urandom_range(0, 15) == 0);
    r.infs = ($urandom_range(0, 15) == 0);
    r.zero = ($urandom_range(0, 15) == 0);
    r.diff = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic send(input rec_t r, input bit expect_out);
    int n;
    logic [63:0] er;
    logic [4:0]  ef;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", bus.in_ready);
    end
    bus.sig  = r.sig;   bus.expo = 14'(r.expo); bus.mant = r.mant[53:0];
    bus.rema = r.rema;  bus.fmt  = r.fmt;       bus.rm   = r.rm;
    bus.grs  = r.grs;   bus.snan = r.snan;      bus.qnan = r.qnan;
    bus.dbz  = r.dbz;   bus.infs = r.infs;      bus.zero = r.zero;
    bus.diff = r.diff;
    bus.in_valid = 1'b1;
    if (expect_out) begin
      model(r, er, ef);
      exp_q.push_back({er, ef});
      cyc_q.push_back(cyc);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  // Consumer ready pattern, changed just after each rising edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every cycle out_valid is high the DUT must show the head record
  always @(negedge clk) begin
    logic [68:0] hd;
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid result=%h required=no_output", bus.result);
      end else begin
        hd = exp_q[0];
        chk("result", bus.result, hd[68:5]);
        chk("fflags", {59'd0, bus.fflags}, {59'd0, hd[4:0]});
        chk("in_ready_busy", {63'd0, bus.in_ready}, 64'd0);
        if (first_pend) chk("latency", 64'(cyc - cyc_q[0]), 64'd3);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
          first_pend = 1'b1;
        end else begin
          first_pend = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [63:0] er, held_r;
    logic [4:0]  ef, held_f;
    rec_t        r;
    int          n;

    rst_n = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.sig = 1'b0; bus.expo = '0; bus.mant = '0; bus.rema = '0;
    bus.fmt = '0; bus.rm = '0; bus.grs = '0; bus.snan = 1'b0; bus.qnan = 1'b0;
    bus.dbz = 1'b0; bus.infs = 1'b0; bus.zero = 1'b0; bus.diff = 1'b0;

    dv[0]  = mk(2'd1, 1023, 64'h0010_0000_0000_0000, 3'b000, 3'd0, 1'b0);
    dres[0] = 64'h3FF0_0000_0000_0000; dfl[0] = 5'b00000;
    dv[1]  = mk(2'd1, 1023, 64'h001F_FFFF_FFFF_FFFF, 3'b100, 3'd0, 1'b0);
    dres[1] = 64'h4000_0000_0000_0000; dfl[1] = 5'b00001;
    dv[2]  = mk(2'd1, 1023, 64'h001F_FFFF_FFFF_FFFF, 3'b100, 3'd1, 1'b0);
    dres[2] = 64'h3FFF_FFFF_FFFF_FFFF; dfl[2] = 5'b00001;
    dv[3]  = mk(2'd0, 255, 64'h80_0000, 3'b000, 3'd1, 1'b0);
    dres[3] = 64'hFFFF_FFFF_7F7F_FFFF; dfl[3] = 5'b00101;
    dv[4]  = mk(2'd0, 255, 64'h80_0000, 3'b000, 3'd0, 1'b0);
    dres[4] = 64'hFFFF_FFFF_7F80_0000; dfl[4] = 5'b00101;
    dv[5]  = mk(2'd1, 0, 0, 3'b000, 3'd0, 1'b0); dv[5].snan = 1'b1;
    dres[5] = 64'h7FF8_0000_0000_0000; dfl[5] = 5'b10000;
    dv[6]  = mk(2'd1, 0, 0, 3'b000, 3'd2, 1'b0); dv[6].zero = 1'b1; dv[6].diff = 1'b1;
    dres[6] = 64'h8000_0000_0000_0000; dfl[6] = 5'b00000;
    dv[7]  = mk(2'd0, 0, 0, 3'b000, 3'd0, 1'b1); dv[7].dbz = 1'b1;
    dres[7] = 64'hFFFF_FFFF_FF80_0000; dfl[7] = 5'b01000;
    dv[8]  = mk(2'd0, 0, 64'h1, 3'b110, 3'd0, 1'b0);
`ifdef FP_RND_FTZ_EN
    dres[8] = 64'hFFFF_FFFF_0000_0000; dfl[8] = 5'b00011;
`else
    dres[8] = 64'hFFFF_FFFF_0000_0002; dfl[8] = 5'b00011;
`endif
    dv[9]  = mk(2'd1, 2047, 64'h0010_0000_0000_0000, 3'b000, 3'd3, 1'b1);
    dres[9] = 64'hFFEF_FFFF_FFFF_FFFF; dfl[9] = 5'b00101;
    dv[10] = mk(2'd0, 0, 0, 3'b000, 3'd0, 1'b0); dv[10].qnan = 1'b1;
    dres[10] = 64'hFFFF_FFFF_7FC0_0000; dfl[10] = 5'b00000;
    dv[11] = mk(2'd0, 127, 64'h80_0000, 3'b100, 3'd4, 1'b0);
    dres[11] = 64'hFFFF_FFFF_3F80_0001; dfl[11] = 5'b00001;
    dv[12] = mk(2'd0, 127, 64'h80_0000, 3'b100, 3'd0, 1'b0);
    dres[12] = 64'hFFFF_FFFF_3F80_0000; dfl[12] = 5'b00001;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_fflags", {59'd0, bus.fflags}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;

    // Anchor vectors: pin the model, then run them through the DUT
    rdy_mode = 1;
    for (int i = 0; i < 13; i++) begin
      model(dv[i], er, ef);
      chk($sformatf("pin_result_%0d", i), er, dres[i]);
      chk($sformatf("pin_fflags_%0d", i), {59'd0, ef}, {59'd0, dfl[i]});
      send(dv[i], 1'b1);
      wait_drain();
    end

    // Back-pressure: result and flags hold while out_ready stays low
    rdy_mode = 2;
    @(negedge clk);
    send(dv[1], 1'b1);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_rise", {63'd0, bus.out_valid}, 64'd1);
    held_r = bus.result;
    held_f = bus.fflags;
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", bus.result, held_r);
      chk("hold_fflags", {59'd0, bus.fflags}, {59'd0, held_f});
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    rdy_mode = 1;
    wait_drain();

    // Flush while the record is in PACK
    send(dv[0], 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("clr_out_valid", {63'd0, bus.out_valid}, 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("clr_no_output", {63'd0, bus.out_valid}, 64'd0);
    end

    // clear alongside in_valid in IDLE must not capture
    bus.in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear = 1'b0;
    chk("clr_idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("clr_idle_no_output", {63'd0, bus.out_valid}, 64'd0);
    end

    // Randomised records with random consumer back-pressure
    rdy_mode = 0;
    repeat (300) begin
      r = rnd_rec();
      send(r, 1'b1);
    end
    rdy_mode = 1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_rnd_seq.md
Name: fp_rnd_seq

Overview:
- Sequential IEEE 754 rounding/packing stage that consumes the unrounded record (sign, exponent, mantissa, guard/round/sticky, exception flags) produced by the FMA, divide and sqrt datapaths.
- Produces the final packed FP32 (NaN-boxed) or FP64 result and the RISC-V fflags.
- Sits between the FP arithmetic units and FPU writeback, with a valid/ready handshake on both sides.

Parameters:
FLEN, 64, packed result width; single results NaN-boxed (upper 32 bits all ones)
EXPW, 14, input exponent width (two's complement)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clear  in  1  synchronous flush
in_valid  in  1  input record valid
in_ready  out  1  block can accept a record
sig  in  1  result sign
expo  in  EXPW  biased exponent; 0 means subnormal/zero
mant  in  54  fmt=0: mant[23:0] with hidden bit 23; fmt=1: mant[52:0] with hidden bit 52
rema  in  2  div/sqrt remainder, ORed into sticky
fmt  in  2  0=single, 1=double
rm  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
grs  in  3  guard, round, sticky
snan qnan dbz infs zero diff  in  1 each  exception/class flags from producer
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  FLEN  packed result
fflags  out  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset and reset values:
  - Reset is synchronous, active-low, rst_n; clock is clk.
  - On reset: state=IDLE, out_valid=0, result=0, fflags=0, in_ready=1.
- States and handshake:
  - States: IDLE, ROUND, PACK, OUT.
  - in_ready = (state==IDLE).
  - IDLE: in_valid=1 captures all inputs into a register, then goes to ROUND.
  - ROUND → PACK unconditionally.
  - PACK → OUT. out_valid is registered and goes high on entry to OUT.
  - OUT: out_valid=1. If out_ready=1, go to IDLE; otherwise hold result and fflags stable.
  - Latency: handshake at edge N gives out_valid=1 in cycle N+3. One record in flight, so throughput is at most 1 per 4 cycles.
- clear:
  - Overrides every state: next state IDLE, out_valid=0 the following cycle.
  - A record in flight is dropped; no partial output.
  - clear together with in_valid in IDLE does not capture the record.
- ROUND cycle:
  - s = grs[0] | rema[1] | rema[0]; inexact = grs[2] | grs[1] | s.
  - Round-up increment:
    - RNE: g & (r | s | lsb).
    - RTZ: 0.
    - RDN: sig & inexact.
    - RUP: ~sig & inexact.
    - RMM: g.
    - rm values 5–7 behave as RNE.
  - Register mant+inc with one extra bit.
  - Carry out of bit 24 (single) or 53 (double): shift right 1, expo+1.
  - Subnormal promotion: if expo==0 and the rounded value sets the hidden bit, expo becomes 1.
- PACK cycle, priority order (first match wins):
  1. snan: canonical NaN, NV=1.
  2. qnan: canonical NaN, flags 0.
  3. dbz: signed infinity, DZ=1.
  4. infs: signed infinity, flags 0.
  5. zero: signed zero. Sign = (rm==RDN) when diff=1, else sig. Flags 0.
  6. Overflow (expo ≥ 255 single / 2047 double): OF=1, NX=1. Result is infinity for RNE/RMM, for RUP with sig=0, and for RDN with sig=1; otherwise max finite.
  7. Otherwise normal/subnormal pack. NX=inexact. UF = (pre-round expo==0) & inexact.
- Canonical NaN: single 64'hFFFFFFFF7FC00000, double 64'h7FF8000000000000.
- Single results always have bits 63:32 = all ones.

Optional Feature:
- Macro FP_RND_FTZ_EN.
- Defined: any result with final expo==0 and nonzero mantissa is flushed to signed zero with UF=1, NX=1. The zero-sign rules of step 5 do not apply to flushed values.
- Undefined: full gradual underflow as above.

Decomposition:
- fp_types package: rounding-mode enum (RNE..RMM), fflags bit indices, canonical-NaN constants, EXPW default, fp_rnd_seq state enum.
- One natural sub-module: fp_rnd_inc, a combinational increment-decision-plus-add, instantiated in ROUND.

Test Plan:
- Exact value: fmt=1, expo=1023, mant=53'h10000000000000, grs=0, rm=RNE → result 64'h3FF0000000000000, fflags 0, out_valid exactly 3 cycles after accept.
- Mantissa carry: fmt=1, expo=1023, mant=53'h1FFFFFFFFFFFFF, grs=3'b100, rm=RNE → 64'h4000000000000000, fflags 5'b00001. Same input with rm=RTZ → 64'h3FFFFFFFFFFFFFFF, NX.
- Overflow by mode: fmt=0, expo=255, mant=24'h800000, sig=0, grs=0:
  - rm=RTZ → 64'hFFFFFFFF7F7FFFFF, fflags 5'b00101.
  - rm=RNE → 64'hFFFFFFFF7F800000, fflags 5'b00101.
- Specials:
  - snan=1, fmt=1 → 64'h7FF8000000000000, NV (5'b10000).
  - zero=1, diff=1, rm=RDN → 64'h8000000000000000, fflags 0.
  - dbz=1, sig=1, fmt=0 → 64'hFFFFFFFFFF800000, DZ.
- Subnormal/underflow: fmt=0, expo=0, mant=24'h000001, grs=3'b110, rm=RNE → 64'hFFFFFFFF00000002, UF|NX. With FP_RND_FTZ_EN → 64'hFFFFFFFF00000000, UF|NX.
- Handshake: hold out_ready=0 for 5 cycles → result stable and in_ready=0 throughout. clear asserted in PACK → out_valid never rises, in_ready=1 next cycle.
